jtag_tap_ctrl: RTL and testbench



---
 rtl/jtag_tap_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// JTAG instruction/data-register controller with a valid/ready debug-request bridge.
// Optional USERCODE data register enabled by defining JTAG_TAP_CTRL_USERCODE_EN.
module jtag_tap_ctrl #(
    parameter int                  IR_WIDTH   = 5,
    parameter logic [31:0]         IDCODE_VAL = 32'h1DC0_0001,
    parameter logic [IR_WIDTH-1:0] OPC_IDCODE = 5'h01,
    parameter logic [IR_WIDTH-1:0] OPC_DBG    = 5'h11,
    parameter int                  DBG_ADDR_W = 6
`ifdef JTAG_TAP_CTRL_USERCODE_EN
    ,
    parameter logic [IR_WIDTH-1:0] OPC_USERCODE = 5'h08,
    parameter logic [31:0]         USERCODE_VAL = 32'h0000_0000
`endif
) (
    input  logic                  tck,
    input  logic                  trst_n,
    input  logic                  tlr,
    input  logic                  capture_ir,
    input  logic                  shift_ir,
    input  logic                  update_ir,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [IR_WIDTH-1:0]   ir_out,
    output logic                  dbg_req_valid,
    input  logic                  dbg_req_ready,
    output logic [1:0]            dbg_req_op,
    output logic [DBG_ADDR_W-1:0] dbg_req_addr,
    output logic [31:0]           dbg_req_data,
    input  logic                  dbg_rsp_valid,
    input  logic [31:0]           dbg_rsp_data
);

    localparam int DW = 2 + DBG_ADDR_W + 32;

    typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DBG, SEL_USERCODE} dr_sel_e;
    typedef enum logic [1:0] {OP_NOP = 2'b00, OP_READ = 2'b01, OP_WRITE = 2'b10, OP_CLR = 2'b11} dbg_op_e;

    logic [IR_WIDTH-1:0]   ir_q, ir_d, ir_sh_q, ir_sh_d;
    logic                  bypass_q, bypass_d;
    logic [31:0]           idcode_sh_q, idcode_sh_d;
    logic [DW-1:0]         dbg_sh_q, dbg_sh_d;
    logic                  busy_q, busy_d, overrun_q, overrun_d;
    logic [31:0]           rsp_q, rsp_d;
    logic                  req_valid_q, req_valid_d;
    logic [1:0]            req_op_q, req_op_d;
    logic [DBG_ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]           req_data_q, req_data_d;
`ifdef JTAG_TAP_CTRL_USERCODE_EN
    logic [31:0]           user_sh_q, user_sh_d;
`endif

    dr_sel_e dr_sel;
    dbg_op_e upd_op;
    logic    dbg_update;
    logic    busy_after_rsp;

    always_comb begin
        dr_sel = SEL_BYPASS;
        if (ir_q == OPC_IDCODE)   dr_sel = SEL_IDCODE;
        else if (ir_q == OPC_DBG) dr_sel = SEL_DBG;
`ifdef JTAG_TAP_CTRL_USERCODE_EN
        else if (ir_q == OPC_USERCODE) dr_sel = SEL_USERCODE;
`endif
    end

    assign upd_op     = dbg_op_e'(dbg_sh_q[1:0]);
    assign dbg_update = update_dr && (dr_sel == SEL_DBG);
    // A response arriving with an update frees the slot before the new request is judged.
    assign busy_after_rsp = busy_q && !dbg_rsp_valid;

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no path can infer a latch.
        ir_d        = ir_q;
        ir_sh_d     = ir_sh_q;
        bypass_d    = bypass_q;
        idcode_sh_d = idcode_sh_q;
        dbg_sh_d    = dbg_sh_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        rsp_d       = rsp_q;
        req_valid_d = req_valid_q;
        req_op_d    = req_op_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
`ifdef JTAG_TAP_CTRL_USERCODE_EN
        user_sh_d   = user_sh_q;
`endif

        if (tlr)            ir_d = OPC_IDCODE;
        else if (update_ir) ir_d = ir_sh_q;

        if (capture_ir)    ir_sh_d = IR_WIDTH'(2'b01);
        else if (shift_ir) ir_sh_d = {tdi, ir_sh_q[IR_WIDTH-1:1]};

        if (capture_dr) begin
            case (dr_sel)
                SEL_IDCODE: idcode_sh_d = IDCODE_VAL;
                SEL_DBG:    dbg_sh_d    = {rsp_q, {DBG_ADDR_W{1'b0}}, overrun_q, busy_q};
`ifdef JTAG_TAP_CTRL_USERCODE_EN
                SEL_USERCODE: user_sh_d = USERCODE_VAL;
`endif
                default:    bypass_d    = 1'b0;
            endcase
        end else if (shift_dr) begin
            case (dr_sel)
                SEL_IDCODE: idcode_sh_d = {tdi, idcode_sh_q[31:1]};
                SEL_DBG:    dbg_sh_d    = {tdi, dbg_sh_q[DW-1:1]};
`ifdef JTAG_TAP_CTRL_USERCODE_EN
                SEL_USERCODE: user_sh_d = {tdi, user_sh_q[31:1]};
`endif
                default:    bypass_d    = tdi;
            endcase
        end

        if (req_valid_q && dbg_req_ready) req_valid_d = 1'b0;

        if (dbg_rsp_valid && busy_q) begin
            rsp_d  = dbg_rsp_data;
            busy_d = 1'b0;
        end

        if (dbg_update) begin
            case (upd_op)
                OP_READ, OP_WRITE: begin
                    if (!busy_after_rsp) begin
                        req_op_d    = dbg_sh_q[1:0];
                        req_addr_d  = dbg_sh_q[2 +: DBG_ADDR_W];
                        req_data_d  = dbg_sh_q[DW-1 -: 32];
                        req_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                OP_CLR:  overrun_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge tck) begin
        if (!trst_n) begin
            ir_q        <= OPC_IDCODE;
            ir_sh_q     <= '0;
            bypass_q    <= 1'b0;
            idcode_sh_q <= '0;
            dbg_sh_q    <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            rsp_q       <= '0;
            req_valid_q <= 1'b0;
            req_op_q    <= '0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
`ifdef JTAG_TAP_CTRL_USERCODE_EN
            user_sh_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            ir_q        <= ir_d;
            ir_sh_q     <= ir_sh_d;
            bypass_q    <= bypass_d;
            idcode_sh_q <= idcode_sh_d;
            dbg_sh_q    <= dbg_sh_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            rsp_q       <= rsp_d;
            req_valid_q <= req_valid_d;
            req_op_q    <= req_op_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
`ifdef JTAG_TAP_CTRL_USERCODE_EN
            user_sh_q   <= user_sh_d;
`endif
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (shift_ir) begin
            tdo = ir_sh_q[0];
        end else if (shift_dr) begin
            case (dr_sel)
                SEL_IDCODE: tdo = idcode_sh_q[0];
                SEL_DBG:    tdo = dbg_sh_q[0];
`ifdef JTAG_TAP_CTRL_USERCODE_EN
                SEL_USERCODE: tdo = user_sh_q[0];
`endif
                default:    tdo = bypass_q;
            endcase
        end
    end

    assign tdo_en        = shift_ir | shift_dr;
    assign ir_out        = ir_q;
    assign dbg_req_valid = req_valid_q;
    assign dbg_req_op    = req_op_q;
    assign dbg_req_addr  = req_addr_q;
    assign dbg_req_data  = req_data_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomized directed bench for jtag_tap_ctrl against a scan-level behavioural model.
module tb_jtag_tap_ctrl;

    localparam int          IR_W       = 5;
    localparam logic [31:0] IDCODE_VAL = 32'h1DC0_0001;
    localparam logic [4:0]  OPC_IDCODE = 5'h01;
    localparam logic [4:0]  OPC_DBG    = 5'h11;
    localparam logic [4:0]  OPC_USER   = 5'h08;
    localparam logic [31:0] USER_VAL   = 32'h0000_0000;

    logic        tck = 1'b0;
    logic        trst_n, tlr, capture_ir, shift_ir, update_ir;
    logic        capture_dr, shift_dr, update_dr, tdi;
    logic        tdo, tdo_en;
    logic [4:0]  ir_out;
    logic        dbg_req_valid, dbg_req_ready;
    logic [1:0]  dbg_req_op;
    logic [5:0]  dbg_req_addr;
    logic [31:0] dbg_req_data;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_data;

    always #5 tck = ~tck;

    jtag_tap_ctrl dut (
        .tck(tck), .trst_n(trst_n), .tlr(tlr),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en), .ir_out(ir_out),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_op(dbg_req_op), .dbg_req_addr(dbg_req_addr), .dbg_req_data(dbg_req_data),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model of the architecturally visible state.
    logic [4:0]  m_ir;
    bit          m_busy, m_ovr, m_valid;
    logic [31:0] m_rsp, m_data;
    logic [1:0]  m_op;
    logic [5:0]  m_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_strobes();
        tlr = 0; capture_ir = 0; shift_ir = 0; update_ir = 0;
        capture_dr = 0; shift_dr = 0; update_dr = 0; tdi = 0;
        dbg_req_ready = 0; dbg_rsp_valid = 0; dbg_rsp_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge tck); clear_strobes();
        end
        #1;
    endtask

    task automatic model_reset();
        m_ir = OPC_IDCODE; m_busy = 0; m_ovr = 0; m_valid = 0;
        m_rsp = '0; m_data = '0; m_op = '0; m_addr = '0;
    endtask

    task automatic model_rsp(input logic [31:0] d);
        if (m_busy) begin
            m_rsp  = d;
            m_busy = 0;
        end
    endtask

    function automatic logic [39:0] dr_expect(input logic [39:0] din, input int n);
        logic [39:0] cap, r;
        int w;
        r = '0;
        if (m_ir == OPC_IDCODE) begin
            cap = {8'h0, IDCODE_VAL}; w = 32;
        end else if (m_ir == OPC_DBG) begin
            cap = {m_rsp, 6'h0, m_ovr, m_busy}; w = 40;
`ifdef JTAG_TAP_CTRL_USERCODE_EN
        end else if (m_ir == OPC_USER) begin
            cap = {8'h0, USER_VAL}; w = 32;
`endif
        end else begin
            cap = '0; w = 1;
        end
        for (int i = 0; i < n; i++) r[i] = (i < w) ? cap[i] : din[i - w];
        return r;
    endfunction

    task automatic scan_ir(input logic [4:0] val, output logic [4:0] dout, output bit en_ok);
        en_ok = 1; dout = '0;
        @(negedge tck); clear_strobes(); capture_ir = 1;
        for (int i = 0; i < IR_W; i++) begin
            @(negedge tck); clear_strobes(); shift_ir = 1; tdi = val[i];
            #1 dout[i] = tdo;
            if (tdo_en !== 1'b1) en_ok = 0;
        end
        @(negedge tck); clear_strobes(); update_ir = 1;
        m_ir = val;
        idle(1);
    endtask

    task automatic scan_dr(input logic [39:0] din, input int n, input bit do_upd,
                           input bit rsp_at_upd, input logic [31:0] rspd,
                           output logic [39:0] dout, output logic [39:0] exp, output bit en_ok);
        exp = dr_expect(din, n);
        dout = '0; en_ok = 1;
        @(negedge tck); clear_strobes(); capture_dr = 1;
        for (int i = 0; i < n; i++) begin
            @(negedge tck); clear_strobes(); shift_dr = 1; tdi = din[i];
            #1 dout[i] = tdo;
            if (tdo_en !== 1'b1) en_ok = 0;
        end
        if (do_upd) begin
            @(negedge tck); clear_strobes(); update_dr = 1;
            if (rsp_at_upd) begin
                dbg_rsp_valid = 1; dbg_rsp_data = rspd;
                model_rsp(rspd);
            end
            if (m_ir == OPC_DBG && n == 40) begin
                if (din[1:0] == 2'b01 || din[1:0] == 2'b10) begin
                    if (!m_busy) begin
                        m_op = din[1:0]; m_addr = din[7:2]; m_data = din[39:8];
                        m_valid = 1; m_busy = 1;
                    end else begin
                        m_ovr = 1;
                    end
                end else if (din[1:0] == 2'b11) begin
                    m_ovr = 0;
                end
            end
        end
        idle(1);
    endtask

    task automatic respond(input logic [31:0] d);
        @(negedge tck); clear_strobes(); dbg_rsp_valid = 1; dbg_rsp_data = d;
        model_rsp(d);
        idle(1);
    endtask

    task automatic accept();
        @(negedge tck); clear_strobes(); dbg_req_ready = 1;
        m_valid = 0;
        idle(1);
    endtask

    task automatic check_req(input string tag);
        check({tag, "_valid"}, dbg_req_valid, m_valid);
        check({tag, "_op"},    dbg_req_op,    m_op);
        check({tag, "_addr"},  dbg_req_addr,  m_addr);
        check({tag, "_data"},  dbg_req_data,  m_data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [39:0] dout, exp, din;
        logic [4:0]  irc, v;
        bit          en;

        clear_strobes();
        trst_n = 0;
        model_reset();
        idle(3);
        @(negedge tck); trst_n = 1;
        #1;
        check("rst_tdo", {tdo_en, tdo}, 2'b00);
        check("rst_ir", ir_out, OPC_IDCODE);
        check_req("rst");

        // IDCODE readout straight after reset.
        scan_dr(40'h0, 32, 0, 0, '0, dout, exp, en);
        check("idcode_scan", dout, exp);
        check("idcode_const", dout[31:0], 32'h1DC0_0001);
        check("tdo_en_shift", en, 1);
        check("tdo_en_idle", {tdo_en, tdo}, 2'b00);

        // All-ones IR selects BYPASS; IR capture pattern is ...01.
        scan_ir(5'h1F, irc, en);
        check("ir_capture", irc, 5'b00001);
        check("ir_tdo_en", en, 1);
        check("ir_1f", ir_out, 5'h1F);
        scan_dr(40'b1101, 4, 0, 0, '0, dout, exp, en);
        check("bypass_scan", dout, exp);
        check("bypass_const", dout[3:0], 4'b1010);

        for (int k = 0; k < 6; k++) begin
            v = 5'($urandom);
            if (k == 0) v = OPC_USER;
            scan_ir(v, irc, en);
            check("rnd_ir_cap", irc, 5'b00001);
            check("rnd_ir_out", ir_out, v);
            din = {8'h0, 32'($urandom)};
            scan_dr(din, 36, 0, 0, '0, dout, exp, en);
            check("rnd_dr_scan", dout, exp);
        end

        // Write request and ready handshake.
        scan_ir(OPC_DBG, irc, en);
        scan_dr({32'hDEAD_BEEF, 6'h05, 2'b10}, 40, 1, 0, '0, dout, exp, en);
        check("wr_cap", dout, exp);
        check_req("wr");
        check("wr_data_const", dbg_req_data, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check_req("wr_hold");
        end
        @(negedge tck); clear_strobes(); dbg_req_ready = 1;
        #1 check("ready_cycle_valid", dbg_req_valid, 1);
        m_valid = 0;
        idle(1);
        check_req("wr_after_ready");
        respond($urandom);

        // Read request, response, then readback via capture.
        scan_dr({32'($urandom), 6'h02, 2'b01}, 40, 1, 0, '0, dout, exp, en);
        check("rd_cap", dout, exp);
        check_req("rd");
        accept();
        respond(32'h1234_5678);
        scan_dr({38'($urandom), 2'b00}, 40, 1, 0, '0, dout, exp, en);
        check("rd_back", dout, exp);
        check("rd_back_const", {dout[39:8], dout[1:0]}, {32'h1234_5678, 2'b00});

        // Overrun, clear-overrun, response coincident with update.
        scan_dr({32'($urandom), 6'($urandom), 2'b01}, 40, 1, 0, '0, dout, exp, en);
        accept();
        scan_dr({32'($urandom), 6'($urandom), 2'b10}, 40, 1, 0, '0, dout, exp, en);
        check_req("ovr_req");
        scan_dr({38'($urandom), 2'b00}, 40, 1, 0, '0, dout, exp, en);
        check("ovr_cap", dout, exp);
        check("ovr_bits", dout[1:0], 2'b11);
        scan_dr({38'($urandom), 2'b11}, 40, 1, 0, '0, dout, exp, en);
        scan_dr({38'($urandom), 2'b00}, 40, 1, 0, '0, dout, exp, en);
        check("clr_bits", dout[1:0], 2'b01);
        scan_dr({32'($urandom), 6'($urandom), 2'b10}, 40, 1, 1, 32'($urandom), dout, exp, en);
        check_req("same_cycle");
        scan_dr({38'($urandom), 2'b00}, 40, 1, 0, '0, dout, exp, en);
        check("same_cycle_cap", dout, exp);
        check("same_cycle_bits", dout[1:0], 2'b01);

        // Test-Logic-Reset leaves the debug side alone.
        @(negedge tck); clear_strobes(); tlr = 1;
        m_ir = OPC_IDCODE;
        idle(1);
        check("tlr_ir", ir_out, OPC_IDCODE);
        check_req("tlr");
        scan_ir(OPC_DBG, irc, en);
        scan_dr({38'($urandom), 2'b00}, 40, 1, 0, '0, dout, exp, en);
        check("tlr_busy", dout, exp);
        check("tlr_busy_bit", dout[0], 1'b1);

        for (int k = 0; k < 24; k++) begin
            din = {32'($urandom), 6'($urandom), 2'($urandom_range(0, 3))};
            scan_dr(din, 40, 1, ($urandom % 4) == 0, 32'($urandom), dout, exp, en);
            check("rnd_dbg_cap", dout, exp);
            check_req("rnd_dbg");
            if ($urandom % 2) accept();
            if ($urandom % 2) respond($urandom);
        end

        // One-cycle synchronous reset.
        @(negedge tck); clear_strobes(); trst_n = 0;
        model_reset();
        @(negedge tck); trst_n = 1;
        #1;
        check("rst2_tdo", {tdo_en, tdo}, 2'b00);
        check("rst2_ir", ir_out, OPC_IDCODE);
        check_req("rst2");
        scan_ir(OPC_DBG, irc, en);
        scan_dr(40'h0, 40, 0, 0, '0, dout, exp, en);
        check("rst2_cap", dout, exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
